sdram_device_model: RTL and testbench

Synthesizable responder for the 16-bit SDR SDRAM interface: the device end of the bus driven by the team's SDRAM controller. Decodes CS/RAS/CAS/WE commands, tracks open rows in four banks, honours the mode register (CAS latency, burst length), and serves burst reads and writes from an internal word array. Used as the memory behind the controller in simulation benches and in FPGA loop-back builds without a real SDRAM. Pad-level tristating of the data bus stays outside this block.

---
 rtl/sdram_device_model.sv | 232 +++++++++++++++++++++++
 tb/tb_sdram_device_model.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sdram_device_model.sv
// SDR SDRAM device responder: command decode, four-bank row tracking, mode register and burst read/write
// from an internal word array. Define SDRAM_MODEL_CHECK_EN to build in the sticky protocol-violation checker.
module sdram_device_model #(
    parameter int unsigned MEM_ADDR_BITS = 8
) (
    input  logic        sdram_clk,
    input  logic        reset_n,
    input  logic        sdram_cke,
    input  logic        sdram_csn,
    input  logic        sdram_rasn,
    input  logic        sdram_casn,
    input  logic        sdram_wen,
    input  logic [12:0] sdram_a,
    input  logic [1:0]  sdram_ba,
    input  logic [1:0]  sdram_dqm,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic        err_bank_closed,
    output logic        err_bank_open,
    output logic        err_mode_busy
);

    typedef enum logic [2:0] {
        CMD_LMR = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_BST = 3'b110,
        CMD_NOP = 3'b111
    } cmd_e;

    typedef enum logic [1:0] {
        IS_IDLE,
        IS_READ,
        IS_WRITE
    } issue_e;

    logic [3:0]  bank_open;
    logic [12:0] bank_row [4];

    logic        cl3;
    logic [2:0]  bl_mask;
    logic        wr_single;

    issue_e      is_state;
    logic [1:0]  is_bank;
    logic [12:0] is_row;
    logic [8:0]  is_col;
    logic [2:0]  is_cnt;
    logic [2:0]  is_last;
    logic        is_ap;

    logic [15:0] pipe_data [3];
    logic [2:0]  pipe_vld;
    logic [2:0]  pipe_msk;

    logic [15:0] mem [2**MEM_ADDR_BITS];

    logic                     cmd_en;
    cmd_e                     cmd;
    logic                     cmd_rw;
    logic                     cmd_acc;
    logic [2:0]               cmd_last;
    logic                     stop_burst;
    logic                     burst_step;
    logic [8:0]               burst_col;
    logic                     acc_en;
    logic                     acc_wr;
    logic [MEM_ADDR_BITS-1:0] acc_idx;
    logic [15:0]              rd_word;
    logic                     rd_masked;

    function automatic logic [MEM_ADDR_BITS-1:0] mem_index(
        input logic [1:0]  ba,
        input logic [12:0] row,
        input logic [8:0]  col
    );
        logic [23:0] full;
        full = {ba, row, col};
        return full[MEM_ADDR_BITS-1:0];
    endfunction

    always_comb begin
        cmd_en     = sdram_cke && !sdram_csn;
        cmd        = cmd_e'({sdram_rasn, sdram_casn, sdram_wen});
        cmd_rw     = cmd_en && (cmd == CMD_RD || cmd == CMD_WR);
        cmd_acc    = cmd_rw && bank_open[sdram_ba];
        cmd_last   = (cmd == CMD_WR && wr_single) ? 3'd0 : bl_mask;
        stop_burst = cmd_acc
                  || (cmd_en && cmd == CMD_BST)
                  || (cmd_en && cmd == CMD_PRE && (sdram_a[10] || sdram_ba == is_bank));
        burst_step = (is_state != IS_IDLE) && sdram_cke && !stop_burst;
        // is_last doubles as the wrap mask: burst lengths are powers of two
        burst_col  = (is_col & ~{6'b0, is_last}) | ((is_col + {6'b0, is_cnt}) & {6'b0, is_last});
        acc_en     = cmd_acc || burst_step;
        acc_wr     = 1'b0;
        acc_idx    = '0;
        if (cmd_acc) begin
            acc_wr  = (cmd == CMD_WR);
            acc_idx = mem_index(sdram_ba, bank_row[sdram_ba], sdram_a[8:0]);
        end else begin
            acc_wr  = (is_state == IS_WRITE);
            acc_idx = mem_index(is_bank, is_row, burst_col);
        end
        rd_word   = mem[acc_idx];
        rd_masked = &sdram_dqm;
    end

    always_ff @(posedge sdram_clk) begin
        if (reset_n && acc_en && acc_wr) begin
            if (!sdram_dqm[0]) mem[acc_idx][7:0]  <= dq_in[7:0];
            if (!sdram_dqm[1]) mem[acc_idx][15:8] <= dq_in[15:8];
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (!reset_n) begin
            bank_open <= '0;
            for (int unsigned b = 0; b < 4; b++) bank_row[b] <= '0;
            cl3       <= 1'b0;
            bl_mask   <= '0;
            wr_single <= 1'b0;
            is_state  <= IS_IDLE;
            is_bank   <= '0;
            is_row    <= '0;
            is_col    <= '0;
            is_cnt    <= '0;
            is_last   <= '0;
            is_ap     <= 1'b0;
            pipe_vld  <= '0;
            pipe_msk  <= '0;
            for (int unsigned p = 0; p < 3; p++) pipe_data[p] <= '0;
            dq_out    <= '0;
            dq_oe     <= 1'b0;
        end else if (sdram_cke) begin
            pipe_vld     <= {pipe_vld[1:0], acc_en && !acc_wr};
            pipe_msk     <= {pipe_msk[1:0], rd_masked};
            pipe_data[0] <= rd_word;
            pipe_data[1] <= pipe_data[0];
            pipe_data[2] <= pipe_data[1];
            if (cl3) begin
                dq_oe  <= pipe_vld[2] && !pipe_msk[2];
                dq_out <= (pipe_vld[2] && !pipe_msk[2]) ? pipe_data[2] : '0;
            end else begin
                dq_oe  <= pipe_vld[1] && !pipe_msk[1];
                dq_out <= (pipe_vld[1] && !pipe_msk[1]) ? pipe_data[1] : '0;
            end

            if (burst_step) begin
                if (is_cnt == is_last) begin
                    is_state <= IS_IDLE;
                    if (is_ap) bank_open[is_bank] <= 1'b0;
                end else begin
                    is_cnt <= is_cnt + 3'd1;
                end
            end else if (stop_burst) begin
                is_state <= IS_IDLE;
            end

            // Command effects come last so they override the burst bookkeeping above
            if (cmd_en) begin
                case (cmd)
                    CMD_ACT: begin
                        bank_open[sdram_ba] <= 1'b1;
                        bank_row[sdram_ba]  <= sdram_a;
                    end
                    CMD_PRE: begin
                        if (sdram_a[10]) bank_open <= '0;
                        else             bank_open[sdram_ba] <= 1'b0;
                    end
                    CMD_LMR: begin
                        case (sdram_a[2:0])
                            3'b001:  bl_mask <= 3'd1;
                            3'b010:  bl_mask <= 3'd3;
                            3'b011:  bl_mask <= 3'd7;
                            default: bl_mask <= 3'd0;
                        endcase
                        cl3       <= (sdram_a[6:4] == 3'b011);
                        wr_single <= sdram_a[9];
                    end
                    CMD_RD, CMD_WR: begin
                        if (cmd_acc) begin
                            is_bank <= sdram_ba;
                            is_row  <= bank_row[sdram_ba];
                            is_col  <= sdram_a[8:0];
                            is_cnt  <= 3'd1;
                            is_last <= cmd_last;
                            is_ap   <= sdram_a[10];
                            if (cmd_last != 3'd0) begin
                                is_state <= (cmd == CMD_WR) ? IS_WRITE : IS_READ;
                            end else begin
                                is_state <= IS_IDLE;
                                if (sdram_a[10]) bank_open[sdram_ba] <= 1'b0;
                            end
                            if (cmd == CMD_WR) begin
                                pipe_vld <= '0;
                                dq_oe    <= 1'b0;
                                dq_out   <= '0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SDRAM_MODEL_CHECK_EN
    always_ff @(posedge sdram_clk) begin
        if (!reset_n) begin
            err_bank_closed <= 1'b0;
            err_bank_open   <= 1'b0;
            err_mode_busy   <= 1'b0;
        end else begin
            if (cmd_rw && !bank_open[sdram_ba])
                err_bank_closed <= 1'b1;
            if (cmd_en && cmd == CMD_ACT && bank_open[sdram_ba])
                err_bank_open <= 1'b1;
            if (cmd_en && cmd == CMD_LMR && ((|bank_open) || is_state != IS_IDLE))
                err_mode_busy <= 1'b1;
        end
    end
`else
    assign err_bank_closed = 1'b0;
    assign err_bank_open   = 1'b0;
    assign err_mode_busy   = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_device_model.sv
// Directed bench for sdram_device_model: cycle-by-cycle vector table plus hand-written BST, closed-bank and CKE sequences.
module tb_sdram_device_model;

    localparam logic [2:0] C_NOP = 3'b111;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_BST = 3'b110;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_LMR = 3'b000;

`ifdef SDRAM_MODEL_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic        sdram_clk = 1'b0;
    logic        reset_n;
    logic        sdram_cke;
    logic        sdram_csn;
    logic        sdram_rasn;
    logic        sdram_casn;
    logic        sdram_wen;
    logic [12:0] sdram_a;
    logic [1:0]  sdram_ba;
    logic [1:0]  sdram_dqm;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        err_bank_closed;
    logic        err_bank_open;
    logic        err_mode_busy;

    sdram_device_model #(.MEM_ADDR_BITS(8)) dut (
        .sdram_clk       (sdram_clk),
        .reset_n         (reset_n),
        .sdram_cke       (sdram_cke),
        .sdram_csn       (sdram_csn),
        .sdram_rasn      (sdram_rasn),
        .sdram_casn      (sdram_casn),
        .sdram_wen       (sdram_wen),
        .sdram_a         (sdram_a),
        .sdram_ba        (sdram_ba),
        .sdram_dqm       (sdram_dqm),
        .dq_in           (dq_in),
        .dq_out          (dq_out),
        .dq_oe           (dq_oe),
        .err_bank_closed (err_bank_closed),
        .err_bank_open   (err_bank_open),
        .err_mode_busy   (err_mode_busy)
    );

    always #5 sdram_clk = ~sdram_clk;

    typedef struct {
        logic [2:0]  c;
        logic [1:0]  ba;
        logic [12:0] a;
        logic [1:0]  dqm;
        logic [15:0] d;
        logic        oe;
        logic [15:0] dq;
    } vec_t;

    vec_t vt[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Present one command, then return 1 time unit after the edge that samples it
    task automatic drive(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                         input logic [1:0] dqm, input logic [15:0] d);
        {sdram_rasn, sdram_casn, sdram_wen} = c;
        sdram_ba  = ba;
        sdram_a   = a;
        sdram_dqm = dqm;
        dq_in     = d;
        @(posedge sdram_clk);
        #1;
    endtask

    task automatic add(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic [1:0] dqm, input logic [15:0] d, input logic oe, input logic [15:0] dq);
        vec_t v;
        v = '{c, ba, a, dqm, d, oe, dq};
        vt.push_back(v);
    endtask

    initial begin
        logic        exp_oe;
        logic [15:0] exp_dq;

        reset_n   = 1'b0;
        sdram_cke = 1'b1;
        sdram_csn = 1'b0;
        drive(C_NOP, 2'd0, 13'h0, 2'b00, 16'h0);
        drive(C_NOP, 2'd0, 13'h0, 2'b00, 16'h0);
        check("reset dq_oe", {15'b0, dq_oe}, 16'h0);
        check("reset dq_out", dq_out, 16'h0);
        check("reset err_closed", {15'b0, err_bank_closed}, 16'h0);
        check("reset err_open", {15'b0, err_bank_open}, 16'h0);
        check("reset err_mode", {15'b0, err_mode_busy}, 16'h0);
        reset_n = 1'b1;

        // CL=2 BL=1: write A5A5 at col 5, read it back the next cycle
        add(C_LMR, 2'd0, 13'h020, 2'b00, 16'h0000, 1'b0, 16'h0000);
        add(C_ACT, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0000);
        add(C_WR,  2'd0, 13'h005, 2'b00, 16'hA5A5, 1'b0, 16'h0000);
        add(C_RD,  2'd0, 13'h005, 2'b00, 16'h0000, 1'b0, 16'h0000);
        add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0000);
        add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'hA5A5);
        add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0000);
        // CL=3 BL=4: burst write 1..4 at cols 4..7, read from col 6 wraps to 3,4,1,2
        add(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0000, 1'b0, 16'h0000);
        add(C_LMR, 2'd0, 13'h032, 2'b00, 16'h0000, 1'b0, 16'h0000);
        add(C_ACT, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0000);
        add(C_WR,  2'd0, 13'h004, 2'b00, 16'h0001, 1'b0, 16'h0000);
        add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0002, 1'b0, 16'h0000);
        add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0003, 1'b0, 16'h0000);
        add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0004, 1'b0, 16'h0000);
        add(C_RD,  2'd0, 13'h006, 2'b00, 16'h0000, 1'b0, 16'h0000);
        add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0000);
        add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0000);
        add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h0003);
        add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h0004);
        add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h0001);
        add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h0002);
        add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0000);
        // Byte mask on write, full mask on read
        add(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0000, 1'b0, 16'h0000);
        add(C_LMR, 2'd0, 13'h020, 2'b00, 16'h0000, 1'b0, 16'h0000);
        add(C_ACT, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0000);
        add(C_WR,  2'd0, 13'h020, 2'b00, 16'hFFFF, 1'b0, 16'h0000);
        add(C_WR,  2'd0, 13'h020, 2'b10, 16'h1234, 1'b0, 16'h0000);
        add(C_RD,  2'd0, 13'h020, 2'b00, 16'h0000, 1'b0, 16'h0000);
        add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0000);
        add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'hFF34);
        add(C_RD,  2'd0, 13'h020, 2'b11, 16'h0000, 1'b0, 16'h0000);
        add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0000);
        add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0000);
        add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0000);

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].c, vt[i].ba, vt[i].a, vt[i].dqm, vt[i].d);
            check($sformatf("vec%0d dq_oe", i), {15'b0, dq_oe}, {15'b0, vt[i].oe});
            if (vt[i].oe) check($sformatf("vec%0d dq_out", i), dq_out, vt[i].dq);
        end
        check("table err_open", {15'b0, err_bank_open}, 16'h0);
        check("table err_mode", {15'b0, err_mode_busy}, 16'h0);

        // CL=2 BL=8 read cut short by BURST TERMINATE after three issued words
        drive(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0);
        drive(C_LMR, 2'd0, 13'h023, 2'b00, 16'h0);
        drive(C_ACT, 2'd0, 13'h000, 2'b00, 16'h0);
        drive(C_WR,  2'd0, 13'h040, 2'b00, 16'h0100);
        for (int k = 1; k < 8; k++) drive(C_NOP, 2'd0, 13'h0, 2'b00, 16'h0100 + 16'(k));
        drive(C_RD, 2'd0, 13'h040, 2'b00, 16'h0);
        for (int i = 1; i <= 7; i++) begin
            drive((i == 3) ? C_BST : C_NOP, 2'd0, 13'h0, 2'b00, 16'h0);
            exp_oe = (i >= 2 && i <= 4);
            exp_dq = 16'h0100 + 16'(i - 2);
            check($sformatf("bst cyc%0d dq_oe", i), {15'b0, dq_oe}, {15'b0, exp_oe});
            if (exp_oe) check($sformatf("bst cyc%0d dq_out", i), dq_out, exp_dq);
        end

        // READ to closed bank 2 is ignored and flagged; reset clears the flag
        drive(C_RD, 2'd2, 13'h000, 2'b00, 16'h0);
        check("closed err set", {15'b0, err_bank_closed}, {15'b0, CHK});
        for (int i = 1; i <= 4; i++) begin
            drive(C_NOP, 2'd0, 13'h0, 2'b00, 16'h0);
            check($sformatf("closed cyc%0d dq_oe", i), {15'b0, dq_oe}, 16'h0);
        end
        check("closed err held", {15'b0, err_bank_closed}, {15'b0, CHK});
        reset_n = 1'b0;
        drive(C_NOP, 2'd0, 13'h0, 2'b00, 16'h0);
        reset_n = 1'b1;
        check("closed err cleared", {15'b0, err_bank_closed}, 16'h0);

        // CL=2 BL=4 read with CKE low for three edges in the middle of the data
        drive(C_LMR, 2'd0, 13'h022, 2'b00, 16'h0);
        drive(C_ACT, 2'd0, 13'h000, 2'b00, 16'h0);
        drive(C_WR,  2'd0, 13'h010, 2'b00, 16'h0011);
        drive(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0022);
        drive(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0033);
        drive(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0044);
        drive(C_RD,  2'd0, 13'h010, 2'b00, 16'h0);
        for (int i = 1; i <= 9; i++) begin
            sdram_cke = !(i >= 4 && i <= 6);
            drive(C_NOP, 2'd0, 13'h0, 2'b00, 16'h0);
            exp_oe = (i >= 2 && i <= 8);
            case (i)
                2:       exp_dq = 16'h0011;
                7:       exp_dq = 16'h0033;
                8:       exp_dq = 16'h0044;
                default: exp_dq = 16'h0022;
            endcase
            check($sformatf("cke cyc%0d dq_oe", i), {15'b0, dq_oe}, {15'b0, exp_oe});
            if (exp_oe) check($sformatf("cke cyc%0d dq_out", i), dq_out, exp_dq);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
